// File: rtl/uint16_display_controller_if.sv
// uint16_display_controller_if: valid/ready value channel from producer to display controller
interface uint16_display_controller_if;
    logic [15:0] in_value;
    logic        in_valid;
    logic        in_ready;
    modport master (output in_value, in_valid, input in_ready);
    modport slave (input in_value, in_valid, output in_ready);
endinterface

// File: rtl/uint16_display_controller.sv
// uint16_display_controller: double-dabble BCD conversion with leading-zero blanking and a scanned 5-digit readout
module uint16_display_controller #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    uint16_display_controller_if.slave    bus,
    output logic                          busy,
    output logic [3:0]                    digit,
    output logic [4:0]                    digit_sel,
    output logic                          frame_start
);
    localparam logic [3:0] EMPTY_DIGIT = 4'd10;
    localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);
    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;
    state_t          state_q, state_d;
    logic [15:0]     bin_q, bin_d;
    logic [19:0]     bcd_q, bcd_d, bcd_adj;
    logic [3:0]      cnt_q, cnt_d;
    logic [4:0][3:0] disp_q, disp_d, blank;
    logic [2:0]      pos_q, pos_d;
    logic [7:0]      div_q, div_d;
    logic            lead;
    // next-state: conversion sequencing, blanking of leading zeros, and the free-running scan
    always_comb begin
        state_d = state_q;
        bin_d = bin_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        disp_d = disp_q;
        lead = 1'b1;
        blank = '0;
        bcd_adj = '0;
        for (int i = 0; i < 5; i++)
            bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] >= 4'd5 ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
        for (int i = 4; i >= 1; i--) begin
            lead = lead && (bcd_q[i*4 +: 4] == 4'd0);
            blank[i] = lead ? EMPTY_DIGIT : bcd_q[i*4 +: 4];
        end
        blank[0] = bcd_q[3:0];
        if (state_q == IDLE && bus.in_valid) begin
            bin_d = bus.in_value;
            bcd_d = '0;
            cnt_d = '0;
            state_d = CONVERT;
        end else if (state_q == CONVERT) begin
            {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
            cnt_d = cnt_q + 4'd1;
            state_d = cnt_q == 4'd15 ? COMMIT : CONVERT;
        end else if (state_q == COMMIT) begin
            disp_d = blank;
            state_d = IDLE;
        end
        div_d = div_q == DIV_LAST ? 8'd0 : div_q + 8'd1;
        pos_d = div_q != DIV_LAST ? pos_q : pos_q == 3'd4 ? 3'd0 : pos_q + 3'd1;
    end
    // state registers with synchronous active-low reset blanking the display
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            disp_q <= {5{EMPTY_DIGIT}};
            pos_q <= '0;
            div_q <= '0;
        end else begin
            state_q <= state_d;
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
            disp_q <= disp_d;
            pos_q <= pos_d;
            div_q <= div_d;
        end
    end
    assign bus.in_ready = state_q == IDLE;
    assign busy = state_q != IDLE;
    assign digit = disp_q[pos_q];
    assign digit_sel = 5'b00001 << pos_q;
    assign frame_start = pos_q == 3'd0 && div_q == 8'd0;
endmodule

// File: doc/uint16_display_controller.md
Name: uint16_display_controller

Overview:
Sequencer for a 5-position, 16-bit unsigned decimal readout built around a single shared `UInt16DigitDisplay` segment decoder.
- Accepts a 16-bit value over a valid/ready handshake.
- Converts it to five BCD digits with a sequential double-dabble, one shift per cycle.
- Blanks leading zeros.
- Time-multiplexes the five stored digits onto the one decoder input with a one-hot position select.
- Sits between the value producer and the decoder plus per-position segment latches.

Parameters:
- SCAN_DIV, 4: clock cycles each position is held before advancing; legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_value  input  16  unsigned value to display.
- in_valid  input  1  in_value is valid.
- in_ready  output  1  controller can accept a value (high only in IDLE).
- busy  output  1  conversion in progress (CONVERT or COMMIT).
- digit  output  4  Digit-typed code for the selected position: 0..9 or EmptyDigit; drives the decoder's digit input.
- digit_sel  output  5  one-hot active position; bit 0 is the least significant digit.
- frame_start  output  1  high during the first cycle a scan frame presents position 0.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-low.
  - While rst_n=0 at a clk edge: state=IDLE, all display registers=EmptyDigit, pos=0, div=0, shift register cleared.
  - Outputs during and after reset: in_ready=1, busy=0, digit_sel=5'b00001, digit=EmptyDigit, frame_start=1.
- State machine: IDLE -> CONVERT -> COMMIT -> IDLE.
  - IDLE:
    - in_ready=1.
    - in_valid&&in_ready at an edge captures in_value into the binary shift register, clears the 20-bit BCD register, sets iteration count=0, and moves to CONVERT.
    - Without a handshake, stay in IDLE.
  - CONVERT:
    - Each cycle, every BCD nibble >=5 gets +3, then {bcd,bin} shifts left by 1.
    - Exactly 16 cycles, counter 0..15; after the 16th shift, go to COMMIT.
    - in_ready=0; in_valid is ignored and no value is buffered.
  - COMMIT (1 cycle):
    - Leading-zero suppression from the most significant position down: a zero nibble becomes EmptyDigit until the first nonzero nibble.
    - Position 0 is never suppressed.
    - The result writes all five display registers at once at the end of the cycle; then go to IDLE.
- Latency:
  - Handshake at edge E.
  - New digits are visible on digit from the cycle after edge E+17.
  - in_ready returns high in that same cycle.
  - Maximum throughput is one value per 18 cycles.
- Double buffering:
  - Display registers change only in COMMIT.
  - Scanning continues with the previous digits throughout CONVERT.
- Scan sequencing:
  - Runs independently of the conversion state, from reset onward.
  - div counts 0..SCAN_DIV-1. When div==SCAN_DIV-1: div->0 and pos->(pos==4 ? 0 : pos+1); otherwise div+1.
  - digit_sel = one-hot(pos). digit = display[pos], combinational from registers.
  - frame_start = (pos==0 && div==0).
- Simultaneous COMMIT and position advance at the same edge: the new position shows the new digit immediately. Partial-frame tearing is accepted.
- Reset mid-CONVERT or mid-COMMIT: the conversion is discarded, no display register is written from it, and the display blanks.
- Arithmetic and widths:
  - BCD register is 20 bits (five nibbles).
  - 65535 fits, so no overflow is possible.
  - All arithmetic is unsigned.

Test Plan:
- Reset, then idle 2*5*SCAN_DIV cycles -> digit=EmptyDigit at all positions; digit_sel cycles 00001,00010,00100,01000,10000, each held 4 cycles; frame_start pulses every 20 cycles; in_ready=1, busy=0.
- Send in_value=0 -> in_ready low for 17 cycles, busy high 17 cycles; then positions 4..0 read E,E,E,E,0.
- Send 65535, then 1000, then 7 back-to-back, with in_valid held high -> second handshake occurs exactly 18 cycles after the first; displays read 6,5,5,3,5 then E,1,0,0,0 then E,E,E,E,7 (positions 4..0).
- Send 10203 while the scan is mid-frame -> old digits stay on digit through all 16 CONVERT cycles; at COMMIT+1 the current position shows its new value; full frame reads 1,0,2,0,3 (interior zeros not blanked).
- Assert rst_n=0 for one cycle at CONVERT iteration 8 of value 4321 -> next cycle is IDLE, display all EmptyDigit, pos=0; 4321 never appears.
- With SCAN_DIV=1, send 9 -> digit_sel advances every cycle; frame_start is high every 5th cycle; position 0 shows 9.
